// File: rtl/synth_pkg.sv
// synth_pkg: shared NCO sizing, slot timing and sequencer state encoding.
// NCO_HARD_SYNC_EN (used by nco_slot_sequencer) enables hard-sync resets.
package synth_pkg;
   localparam int VOICES   = 8;
   localparam int V_OSC    = 4;
   localparam int V_ENVS   = 8;
   localparam int V_WIDTH  = 3;
   localparam int O_WIDTH  = 2;
   localparam int SLOT_DIV = 4;

   typedef logic [1:0] state_t;
   localparam state_t IDLE     = 2'd0;
   localparam state_t RUN      = 2'd1;
   localparam state_t STOPPING = 2'd2;

   // Reset bits of the oscillators strictly above ox (ox owns bit 2*ox)
   function automatic logic [V_ENVS-1:0] upper_osc_mask(
      input logic [O_WIDTH-1:0] ox
   );
      logic [V_ENVS-1:0] m;
      m = '0;
      for (int b = 0; b < V_ENVS; b++)
         m[b] = (b >= 2 * int'(ox) + 2);
      return m;
   endfunction
endpackage

// File: rtl/nco_slot_clkgen.sv
// nco_slot_clkgen: slot cycle counter, the two slot strobes and the
// end-of-slot wrap pulse. Everything is held at zero while disabled.
module nco_slot_clkgen
   import synth_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_osc,
   output logic o_envs,
   output logic o_wrap,
   output logic o_first
);
   localparam int CW = $clog2(SLOT_DIV);
   localparam logic [CW-1:0] LAST = CW'(SLOT_DIV - 1);

   logic          r_act;
   logic [CW-1:0] r_cnt;
   logic          r_osc;
   logic          r_envs;
   logic [CW-1:0] w_cnt_nxt;

   assign o_wrap    = r_act && (r_cnt == LAST);
   assign o_first   = !r_act;
   assign o_osc     = r_osc;
   assign o_envs    = r_envs;
   assign w_cnt_nxt = (!r_act || o_wrap) ? '0 : r_cnt + CW'(1);

   // Slot counter with strobes registered from the next count
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_act  <= 1'b0;
         r_cnt  <= '0;
         r_osc  <= 1'b0;
         r_envs <= 1'b0;
      end else if (!i_en) begin
         r_act  <= 1'b0;
         r_cnt  <= '0;
         r_osc  <= 1'b0;
         r_envs <= 1'b0;
      end else begin
         r_act  <= 1'b1;
         r_cnt  <= w_cnt_nxt;
         r_osc  <= int'(w_cnt_nxt) < SLOT_DIV / 2;
         r_envs <= (int'(w_cnt_nxt) >= SLOT_DIV / 4) &&
                   (int'(w_cnt_nxt) < SLOT_DIV / 4 + SLOT_DIV / 2);
      end
   end
endmodule

// File: rtl/nco_slot_sequencer.sv
// nco_slot_sequencer: scans voice/oscillator slots for the shared NCO RAM
// and presents queued phase resets. NCO_HARD_SYNC_EN adds hard-sync input.
module nco_slot_sequencer
   import synth_pkg::*;
(
   input  logic               OSC_CLK,
   input  logic               reset_reg,
   input  logic               run,
   input  logic               keyon_req,
   input  logic [V_WIDTH-1:0] keyon_voice,
   input  logic [V_ENVS-1:0]  keyon_mask,
`ifdef NCO_HARD_SYNC_EN
   input  logic               osc_wrap,
   input  logic [V_ENVS-1:0]  sync_mask,
`endif
   output logic               keyon_ack,
   output logic               sCLK_XVXOSC,
   output logic               sCLK_XVXENVS,
   output logic [V_WIDTH-1:0] vx,
   output logic [O_WIDTH-1:0] ox,
   output logic [V_ENVS-1:0]  osc_accum_zero,
   output logic               frame_start,
   output logic               busy
);
   localparam logic [V_WIDTH-1:0] V_LAST = V_WIDTH'(VOICES - 1);
   localparam logic [O_WIDTH-1:0] O_LAST = O_WIDTH'(V_OSC - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [V_WIDTH-1:0] r_vx;
   logic [V_WIDTH-1:0] w_vx_nxt;
   logic [O_WIDTH-1:0] r_ox;
   logic [O_WIDTH-1:0] w_ox_nxt;
   logic [V_ENVS-1:0]  r_pend [VOICES];
   logic [V_ENVS-1:0]  w_pend_nxt [VOICES];
   logic [V_ENVS-1:0]  r_oaz;
   logic [V_ENVS-1:0]  w_hs;
   logic [V_ENVS-1:0]  w_hs_keep;
   logic               r_ack;
   logic               r_fs;
   logic               r_busy;
   logic               w_en;
   logic               w_wrap;
   logic               w_first;
   logic               w_acc;
   logic               w_acc_ok;
   logic               w_clr;
   logic               w_frame_end;
   logic               w_load;

   nco_slot_clkgen u_clkgen (
      .i_clk   (OSC_CLK),
      .i_rst   (reset_reg),
      .i_en    (w_en),
      .o_osc   (sCLK_XVXOSC),
      .o_envs  (sCLK_XVXENVS),
      .o_wrap  (w_wrap),
      .o_first (w_first)
   );

   assign w_en        = (w_state_nxt != IDLE);
   assign w_clr       = w_wrap && (r_ox == O_LAST);
   assign w_frame_end = w_clr && (r_vx == V_LAST);
   assign w_load      = w_first || w_clr;
   assign w_acc       = keyon_req && !r_ack;
   assign w_acc_ok    = w_acc && (int'(keyon_voice) < VOICES);

`ifdef NCO_HARD_SYNC_EN
   logic [V_ENVS-1:0] r_hs;

   assign w_hs = (osc_wrap && !w_first) ?
                 (sync_mask & upper_osc_mask(r_ox)) : '0;
   assign w_hs_keep = r_hs | w_hs;

   // Sync bits raised during this voice survive its end-of-voice clear
   always_ff @(posedge OSC_CLK or posedge reset_reg) begin
      if (reset_reg)
         r_hs <= '0;
      else if (w_clr)
         r_hs <= '0;
      else
         r_hs <= r_hs | w_hs;
   end
`else
   assign w_hs      = '0;
   assign w_hs_keep = '0;
`endif

   // Run/stop FSM; a stop request finishes the current frame
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (run) w_state_nxt = RUN;
         RUN:      if (!run) w_state_nxt = STOPPING;
         STOPPING: begin
            if (run)
               w_state_nxt = RUN;
            else if (w_frame_end)
               w_state_nxt = IDLE;
         end
         default:  w_state_nxt = IDLE;
      endcase
   end

   // Voice/oscillator scan: ox inner, vx outer
   always_comb begin
      w_vx_nxt = r_vx;
      w_ox_nxt = r_ox;
      if (!w_en) begin
         w_vx_nxt = '0;
         w_ox_nxt = '0;
      end else if (w_wrap) begin
         w_ox_nxt = (r_ox == O_LAST) ? '0 : r_ox + O_WIDTH'(1);
         if (r_ox == O_LAST)
            w_vx_nxt = (r_vx == V_LAST) ? '0 : r_vx + V_WIDTH'(1);
      end
   end

   // Pending masks: clear at end of voice first, then key-on sets win
   always_comb begin
      for (int i = 0; i < VOICES; i++) begin
         w_pend_nxt[i] = r_pend[i];
         if (int'(r_vx) == i)
            w_pend_nxt[i] = w_clr ? w_hs_keep : (r_pend[i] | w_hs);
         if (w_acc_ok && int'(keyon_voice) == i)
            w_pend_nxt[i] = w_pend_nxt[i] | keyon_mask;
      end
   end

   // Pending RAM
   always_ff @(posedge OSC_CLK or posedge reset_reg) begin
      if (reset_reg) begin
         for (int i = 0; i < VOICES; i++)
            r_pend[i] <= '0;
      end else begin
         for (int i = 0; i < VOICES; i++)
            r_pend[i] <= w_pend_nxt[i];
      end
   end

   // State, indices and registered status outputs
   always_ff @(posedge OSC_CLK or posedge reset_reg) begin
      if (reset_reg) begin
         r_state <= IDLE;
         r_vx    <= '0;
         r_ox    <= '0;
         r_ack   <= 1'b0;
         r_fs    <= 1'b0;
         r_busy  <= 1'b0;
         r_oaz   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_vx    <= w_vx_nxt;
         r_ox    <= w_ox_nxt;
         r_ack   <= w_acc;
         r_busy  <= w_en;
         r_fs    <= w_en && (w_first ||
                    (w_wrap && w_vx_nxt == '0 && w_ox_nxt == '0));
         if (!w_en)
            r_oaz <= '0;
         else if (w_load)
            r_oaz <= w_pend_nxt[w_vx_nxt];
      end
   end

   assign vx             = r_vx;
   assign ox             = r_ox;
   assign keyon_ack      = r_ack;
   assign frame_start    = r_fs;
   assign busy           = r_busy;
   assign osc_accum_zero = r_oaz;
endmodule

// File: tb/tb_nco_slot_sequencer.sv
// tb_nco_slot_sequencer: frame-position reference model with an
// expected-output queue, key-on vector table and directed corner cases.
module tb_nco_slot_sequencer;
   import synth_pkg::*;

   logic       OSC_CLK     = 1'b0;
   logic       reset_reg   = 1'b1;
   logic       run         = 1'b0;
   logic       keyon_req   = 1'b0;
   logic [2:0] keyon_voice = 3'd0;
   logic [7:0] keyon_mask  = 8'h00;
`ifdef NCO_HARD_SYNC_EN
   logic       osc_wrap    = 1'b0;
   logic [7:0] sync_mask   = 8'h00;
`endif
   logic       keyon_ack;
   logic       sCLK_XVXOSC;
   logic       sCLK_XVXENVS;
   logic [2:0] vx;
   logic [1:0] ox;
   logic [7:0] osc_accum_zero;
   logic       frame_start;
   logic       busy;

   nco_slot_sequencer dut (
      .OSC_CLK        (OSC_CLK),
      .reset_reg      (reset_reg),
      .run            (run),
      .keyon_req      (keyon_req),
      .keyon_voice    (keyon_voice),
      .keyon_mask     (keyon_mask),
`ifdef NCO_HARD_SYNC_EN
      .osc_wrap       (osc_wrap),
      .sync_mask      (sync_mask),
`endif
      .keyon_ack      (keyon_ack),
      .sCLK_XVXOSC    (sCLK_XVXOSC),
      .sCLK_XVXENVS   (sCLK_XVXENVS),
      .vx             (vx),
      .ox             (ox),
      .osc_accum_zero (osc_accum_zero),
      .frame_start    (frame_start),
      .busy           (busy)
   );

   always #5 OSC_CLK = ~OSC_CLK;

   typedef struct packed {
      logic       osc;
      logic       envs;
      logic [2:0] vx;
      logic [1:0] ox;
      logic       fs;
      logic       busy;
      logic       ack;
      logic [7:0] oaz;
   } exp_t;

   typedef struct {
      int         at_p;
      logic [2:0] v;
      logic [7:0] m;
      logic [7:0] exp_oaz;
      logic [7:0] exp_next;
   } kv_t;

   exp_t sb [$];
   int   n_vec = 0;
   int   n_err = 0;

   int         m_st;
   int         m_p;
   bit         m_act;
   bit         m_ack;
   logic [7:0] m_pend [8];
   logic [7:0] m_oaz;
   logic [7:0] m_hs;

   function automatic exp_t dut_out();
      exp_t g;
      g.osc  = sCLK_XVXOSC;
      g.envs = sCLK_XVXENVS;
      g.vx   = vx;
      g.ox   = ox;
      g.fs   = frame_start;
      g.busy = busy;
      g.ack  = keyon_ack;
      g.oaz  = osc_accum_zero;
      return g;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st  = 0;
      m_p   = 0;
      m_act = 0;
      m_ack = 0;
      m_oaz = 8'h00;
      m_hs  = 8'h00;
      for (int i = 0; i < 8; i++) m_pend[i] = 8'h00;
      sb.delete();
   endtask

   // One clock: predict outputs after the edge, push, then pop and compare
   task automatic step();
      bit         acc;
      bit         nact;
      int         nst;
      int         np;
      logic [7:0] hs;
      exp_t       e;
      exp_t       got;
      acc = keyon_req && !m_ack;
      hs  = 8'h00;
`ifdef NCO_HARD_SYNC_EN
      if (m_act && osc_wrap)
         for (int b = 0; b < 8; b++)
            if (b >= 2 * ((m_p / 4) % 4) + 2) hs[b] = sync_mask[b];
`endif
      if (m_act && (m_p % 16) == 15) begin
         m_pend[m_p / 16] = m_hs | hs;
         m_hs = 8'h00;
      end else if (m_act) begin
         m_pend[m_p / 16] |= hs;
         m_hs |= hs;
      end
      if (acc) m_pend[keyon_voice] |= keyon_mask;
      nst = m_st;
      case (m_st)
         0: if (run) nst = 1;
         1: if (!run) nst = 2;
         default: begin
            if (run) nst = 1;
            else if (m_act && m_p == 127) nst = 0;
         end
      endcase
      nact = (nst != 0);
      np = (!nact || !m_act) ? 0 : (m_p + 1) % 128;
      if (!nact) m_oaz = 8'h00;
      else if (!m_act || (np % 16) == 0) m_oaz = m_pend[np / 16];
      e.osc  = nact && (np % 4) < 2;
      e.envs = nact && ((np % 4) == 1 || (np % 4) == 2);
      e.vx   = 3'(np / 16);
      e.ox   = 2'((np / 4) % 4);
      e.fs   = nact && np == 0;
      e.busy = nact;
      e.ack  = acc;
      e.oaz  = m_oaz;
      m_st  = nst;
      m_act = nact;
      m_p   = np;
      m_ack = acc;
      sb.push_back(e);
      @(posedge OSC_CLK);
      @(negedge OSC_CLK);
      got = dut_out();
      e = sb.pop_front();
      n_vec++;
      if (got !== e) begin
         n_err++;
         $display("FAIL cycle p=%0d: got %h expected %h", m_p, got, e);
      end
   endtask

   task automatic run_to(input int p);
      int n;
      n = 0;
      while (!(m_act && m_p == p) && n < 400) begin
         step();
         n++;
      end
      if (!(m_act && m_p == p)) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout run_to %0d: got p=%0d expected p=%0d", p, m_p, p);
      end
   endtask

   task automatic keyon(input logic [2:0] v, input logic [7:0] m);
      keyon_req   = 1'b1;
      keyon_voice = v;
      keyon_mask  = m;
      step();
      keyon_req = 1'b0;
      step();
   endtask

   kv_t tbl [5];

   initial begin
      int fs_first;
      int fs_cnt;
      int acks;
      int n;

      tbl[0] = '{33, 3'd5, 8'hFF, 8'hFF, 8'h00};
      tbl[1] = '{63, 3'd3, 8'h01, 8'h01, 8'h00};
      tbl[2] = '{70, 3'd6, 8'h00, 8'h00, 8'h00};
      tbl[3] = '{20, 3'd7, 8'h81, 8'h81, 8'h00};
      tbl[4] = '{40, 3'd1, 8'h0F, 8'h0F, 8'h00};

      // reset state
      model_reset();
      repeat (3) @(negedge OSC_CLK);
      chk("reset_outputs", dut_out(), 32'h0);
      reset_reg = 1'b0;

      // idle with run low
      repeat (50) step();

      // free-running frames
      run = 1'b1;
      fs_first = -1;
      fs_cnt = 0;
      n = 0;
      for (int k = 0; k < 300; k++) begin
         step();
         if (frame_start) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = k;
            else if (fs_cnt == 2) n = k - fs_first;
         end
      end
      chk("frame_period", n, 128);
      chk("frame_count", fs_cnt, 3);

      // key-on vector table
      for (int i = 0; i < 5; i++) begin
         run_to(tbl[i].at_p);
         keyon(tbl[i].v, tbl[i].m);
         run_to(int'(tbl[i].v) * 16);
         chk($sformatf("oaz_voice%0d", i), osc_accum_zero, tbl[i].exp_oaz);
         run_to(((int'(tbl[i].v) + 1) % 8) * 16);
         chk($sformatf("oaz_after%0d", i), osc_accum_zero, tbl[i].exp_next);
      end

      // held request is accepted every second cycle
      run_to(8);
      keyon_req   = 1'b1;
      keyon_voice = 3'd4;
      keyon_mask  = 8'h02;
      acks = 0;
      repeat (4) begin
         step();
         if (keyon_ack) acks++;
      end
      keyon_req = 1'b0;
      step();
      chk("ack_spacing", acks, 2);
      run_to(64);
      chk("oaz_held_req", osc_accum_zero, 8'h02);

`ifdef NCO_HARD_SYNC_EN
      // hard sync at slot (4,1)
      run_to(68);
      osc_wrap  = 1'b1;
      sync_mask = 8'hFF;
      step();
      osc_wrap  = 1'b0;
      run_to(64);
      chk("hard_sync", osc_accum_zero, 8'hF0);
`endif

      // stop at vx=1, finish frame, key-on while idle, restart
      run_to(16);
      run = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (busy && n < 300);
      chk("stop_cycles", n, 112);
      repeat (5) step();
      chk("idle_vx", vx, 3'd0);
      keyon(3'd0, 8'h3C);
      step();
      run = 1'b1;
      step();
      chk("restart_fs", frame_start, 1'b1);
      chk("restart_oaz", osc_accum_zero, 8'h3C);

      // asynchronous reset mid-frame drops pending requests
      run_to(40);
      keyon(3'd7, 8'hFF);
      run_to(50);
      reset_reg = 1'b1;
      #1;
      chk("async_reset", dut_out(), 32'h0);
      model_reset();
      @(negedge OSC_CLK);
      reset_reg = 1'b0;
      run_to(112);
      chk("reset_dropped", osc_accum_zero, 8'h00);
      run_to(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
